// File: rtl/aes_sbox_arb.sv
// Arbiter and sequencer sharing one 128-bit AES S-box engine between the cipher
// round datapath (requester 0) and the key schedule (requester 1).
module aes_sbox_arb #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_W        = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_i,
  input  logic         decrypt0_i,
  input  logic [127:0] data0_i,
  input  logic         req1_i,
  input  logic         decrypt1_i,
  input  logic [127:0] data1_i,
  output logic         ack0_o,
  output logic         ack1_o,
  output logic         done0_o,
  output logic         done1_o,
  output logic [127:0] result_o,
  output logic         err_o,
  output logic         busy_o,
  output logic         sbox_start_o,
  output logic         sbox_decrypt_o,
  output logic [127:0] sbox_data_o,
  input  logic [127:0] sbox_data_i,
  input  logic         sbox_ready_i
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    WAIT  = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state_q, state_d;
  logic            owner_q;
  logic            last_grant_q;
  logic            sel;
  logic [TO_W-1:0] cnt_q;
  logic            start_d;
  logic            ack0_d, ack1_d;
  logic            done0_d, done1_d;
  logic            err_d;

  // Next-state and next-output decode; every output is registered from these
  always_comb begin
    state_d = state_q;
    sel     = 1'b0;
    start_d = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err_d   = 1'b0;

    // Lone requester wins; on a tie the one not granted last time wins
    if (req0_i && req1_i) sel = ~last_grant_q;
    else                  sel = req1_i;

    unique case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          state_d = ISSUE;
          start_d = 1'b1;
          ack0_d  = ~sel;
          ack1_d  = sel;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (sbox_ready_i) begin
          state_d = DONE;
          done0_d = ~owner_q;
          done1_d = owner_q;
        end else if (cnt_q == TO_LAST) begin
          state_d = DONE;
          done0_d = ~owner_q;
          done1_d = owner_q;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      cnt_q          <= '0;
      sbox_start_o   <= 1'b0;
      sbox_decrypt_o <= 1'b0;
      sbox_data_o    <= '0;
      ack0_o         <= 1'b0;
      ack1_o         <= 1'b0;
      done0_o        <= 1'b0;
      done1_o        <= 1'b0;
      err_o          <= 1'b0;
      busy_o         <= 1'b0;
      result_o       <= '0;
    end else begin
      state_q      <= state_d;
      sbox_start_o <= start_d;
      ack0_o       <= ack0_d;
      ack1_o       <= ack1_d;
      done0_o      <= done0_d;
      done1_o      <= done1_d;
      err_o        <= err_d;
      busy_o       <= (state_d != IDLE);

      if (start_d) begin
        owner_q        <= sel;
        last_grant_q   <= sel;
        sbox_data_o    <= sel ? data1_i : data0_i;
        sbox_decrypt_o <= sel ? decrypt1_i : decrypt0_i;
      end

      if (state_q == ISSUE)     cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + TO_W'(1);

      // Ready takes priority over a coincident timeout
      if (state_q == WAIT) begin
        if (sbox_ready_i)           result_o <= sbox_data_i;
        else if (cnt_q == TO_LAST)  result_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_aes_sbox_arb.sv
// Scoreboard bench for aes_sbox_arb: directed requests push expected grants and
// completions; a monitor pops and compares them as the DUT presents ack/done.
module tb_aes_sbox_arb;

  localparam int unsigned TO = 16;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] MASK_E = {16{8'h5a}};
  localparam logic [127:0] MASK_D = {16{8'ha5}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_i = 1'b0, decrypt0_i = 1'b0;
  logic [127:0] data0_i = '0;
  logic         req1_i = 1'b0, decrypt1_i = 1'b0;
  logic [127:0] data1_i = '0;
  logic         ack0_o, ack1_o, done0_o, done1_o, err_o, busy_o;
  logic         sbox_start_o, sbox_decrypt_o;
  logic [127:0] result_o, sbox_data_o;
  logic [127:0] sbox_data_i;
  logic         sbox_ready_i;

  always #5 clk = ~clk;

  aes_sbox_arb #(.TIMEOUT_CYC(TO), .TO_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_i(req0_i), .decrypt0_i(decrypt0_i), .data0_i(data0_i),
    .req1_i(req1_i), .decrypt1_i(decrypt1_i), .data1_i(data1_i),
    .ack0_o(ack0_o), .ack1_o(ack1_o), .done0_o(done0_o), .done1_o(done1_o),
    .result_o(result_o), .err_o(err_o), .busy_o(busy_o),
    .sbox_start_o(sbox_start_o), .sbox_decrypt_o(sbox_decrypt_o),
    .sbox_data_o(sbox_data_o), .sbox_data_i(sbox_data_i),
    .sbox_ready_i(sbox_ready_i)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic         owner;
    logic [127:0] res;
    logic         err;
    int           delta;
  } exp_t;

  exp_t done_q[$];
  logic grant_q[$];
  logic outstanding = 1'b0;
  int   ack_cyc = 0;

  // Engine model: PT<->CT for the reference vector, a fixed XOR mask otherwise
  logic         eng_pend = 1'b0, eng_dec = 1'b0, eng_rdy = 1'b0, eng_mute = 1'b0;
  logic         mode_slip = 1'b0;
  int           eng_cnt = 0, eng_lat = 3;
  logic [127:0] eng_in = '0, eng_res = '0;
  logic         stray_rdy = 1'b0;
  logic [127:0] stray_data = '0;

  assign sbox_ready_i = eng_rdy | stray_rdy;
  assign sbox_data_i  = stray_rdy ? stray_data : eng_res;

  function automatic logic [127:0] xform(input logic [127:0] d, input logic dec);
    if (!dec && d == PT) return CT;
    if (dec && d == CT)  return PT;
    return dec ? (d ^ MASK_D) : (d ^ MASK_E);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      eng_rdy = 1'b0;
      if (!rst_n) begin
        eng_pend = 1'b0;
      end else if (sbox_start_o) begin
        eng_pend = !eng_mute;
        eng_cnt  = eng_lat;
        eng_in   = sbox_data_o;
        eng_dec  = sbox_decrypt_o;
      end else if (eng_pend) begin
        if (sbox_decrypt_o !== eng_dec) mode_slip = 1'b1;
        if (eng_cnt <= 1) begin
          eng_rdy  = 1'b1;
          eng_res  = xform(eng_in, eng_dec);
          eng_pend = 1'b0;
        end else begin
          eng_cnt--;
        end
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    logic g;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (sbox_start_o) begin
          chk("start_has_ack", 128'(ack0_o | ack1_o), 128'd1);
          chk("single_outstanding", 128'(outstanding), 128'd0);
          outstanding = 1'b1;
        end
        if (ack0_o || ack1_o) begin
          ack_cyc = cyc;
          chk("ack_has_start", 128'(sbox_start_o), 128'd1);
          if (grant_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_ack: got ack1/ack0=%b%b expected none", ack1_o, ack0_o);
          end else begin
            g = grant_q.pop_front();
            chk("grant_owner", 128'({ack1_o, ack0_o}), g ? 128'd2 : 128'd1);
          end
        end
        if (done0_o || done1_o) begin
          outstanding = 1'b0;
          if (done_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_done: got done1/done0=%b%b expected none", done1_o, done0_o);
          end else begin
            e = done_q.pop_front();
            chk("done_owner", 128'({done1_o, done0_o}), e.owner ? 128'd2 : 128'd1);
            chk("result", result_o, e.res);
            chk("err", 128'(err_o), 128'(e.err));
            if (e.delta >= 0) chk("latency", 128'(cyc - ack_cyc), 128'(e.delta));
          end
        end
      end
    end
  end

  task automatic push_op(input logic owner, input logic [127:0] res, input logic err, input int delta);
    exp_t e;
    e.owner = owner; e.res = res; e.err = err; e.delta = delta;
    grant_q.push_back(owner);
    done_q.push_back(e);
  endtask

  task automatic drop_req(input int n);
    if (n == 0) req0_i = 1'b0;
    else        req1_i = 1'b0;
  endtask

  // Called at a negedge; holds the request until the matching ack is seen
  task automatic request(input int n, input logic dec, input logic [127:0] d);
    if (n == 0) begin req0_i = 1'b1; decrypt0_i = dec; data0_i = d; end
    else        begin req1_i = 1'b1; decrypt1_i = dec; data1_i = d; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((n == 0 && ack0_o) || (n == 1 && ack1_o)) begin
        drop_req(n);
        return;
      end
    end
    checks++;
    $display("FAIL ack_timeout: got no ack%0d expected ack within 200 cycles", n);
    drop_req(n);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((n == 0 && done0_o) || (n == 1 && done1_o)) return;
    end
    checks++;
    $display("FAIL done_timeout: got no done%0d expected done within 200 cycles", n);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, 128'({ack0_o, ack1_o, done0_o, done1_o, err_o, busy_o,
                              sbox_start_o, sbox_decrypt_o}), 128'd0);
    chk({tag, "_result"}, result_o, '0);
    chk({tag, "_sbox_data"}, sbox_data_o, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  localparam logic [127:0] A0 = 128'h0102030405060708090a0b0c0d0e0f10;
  localparam logic [127:0] B0 = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] A1 = 128'h11111111222222223333333344444444;
  localparam logic [127:0] B1 = 128'hdeadbeefcafef00d0badf00d12345678;
  localparam logic [127:0] D5 = 128'h00000000000000000000000000000001;

  initial begin
    idle(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Encrypt on requester 0
    push_op(1'b0, CT, 1'b0, 4);
    request(0, 1'b0, PT);
    wait_done(0);
    idle(2);

    // Decrypt on requester 1, mode must hold through WAIT
    mode_slip = 1'b0;
    push_op(1'b1, PT, 1'b0, 4);
    request(1, 1'b1, CT);
    wait_done(1);
    chk("decrypt_mode_held", 128'(mode_slip), 128'd0);
    idle(2);

    // Tie from reset, both re-requesting: grants 0,1,0,1
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    push_op(1'b0, A0 ^ MASK_E, 1'b0, 4);
    push_op(1'b1, B0 ^ MASK_D, 1'b0, 4);
    push_op(1'b0, A1 ^ MASK_E, 1'b0, 4);
    push_op(1'b1, B1 ^ MASK_D, 1'b0, 4);
    fork
      begin request(0, 1'b0, A0); wait_done(0); request(0, 1'b0, A1); wait_done(0); end
      begin request(1, 1'b1, B0); wait_done(1); request(1, 1'b1, B1); wait_done(1); end
    join
    idle(2);

    // Timeout: ack at cycle c, WAIT at c+1 edge, done visible 17 negedges after ack
    eng_mute = 1'b1;
    push_op(1'b0, '0, 1'b1, TO + 1);
    request(0, 1'b0, PT);
    wait_done(0);
    eng_mute = 1'b0;
    idle(1);
    push_op(1'b1, D5 ^ MASK_D, 1'b0, 4);
    request(1, 1'b1, D5);
    wait_done(1);
    idle(2);

    // Reset during WAIT drops the operation
    eng_lat = 10;
    grant_q.push_back(1'b0);
    request(0, 1'b0, PT);
    idle(3);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midop_reset");
    done_q.delete();
    grant_q.delete();
    outstanding = 1'b0;
    idle(2);
    rst_n = 1'b1;
    eng_lat = 3;
    idle(5);
    push_op(1'b0, A1 ^ MASK_E, 1'b0, 4);
    push_op(1'b1, B1 ^ MASK_D, 1'b0, 4);
    fork
      begin request(0, 1'b0, A1); wait_done(0); end
      begin request(1, 1'b1, B1); wait_done(1); end
    join
    idle(2);

    // Stray ready in IDLE is ignored
    stray_data = 128'hffffffffffffffffffffffffffffffff;
    stray_rdy  = 1'b1;
    idle(1);
    stray_rdy  = 1'b0;
    idle(4);
    chk("stray_result_held", result_o, B1 ^ MASK_D);
    chk("stray_not_busy", 128'(busy_o), 128'd0);

    chk("scoreboard_drained", 128'(done_q.size() + grant_q.size()), 128'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
